// File: rtl/ahb_arb_grant_ctrl.sv
// Per-slave AHB arbiter back end: picks one winner from raw_grant, holds it for the burst,
// and provides address-phase and data-phase master indices for the slave-side muxes.
module ahb_arb_grant_ctrl #(
  parameter int unsigned REQ_NUM  = 8,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [REQ_NUM-1:0] raw_grant,
  input  logic [REQ_NUM-1:0] hlast,
  input  logic               hsel,
  input  logic               hready,
  output logic [REQ_NUM-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   hmaster_addr,
  output logic [IDX_W-1:0]   hmaster_data,
  output logic               data_valid
);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e             state_q, state_d;
  logic [REQ_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               data_valid_q, data_valid_d;

  logic [REQ_NUM-1:0] cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic               rel;

  // The current owner never competes in its own handover.
  assign cand = (state_q == StOwn) ? (raw_grant & ~grant_q) : raw_grant;

  assign rel = hready & ((hsel & hlast[addr_q]) | (~hsel & ~raw_grant[addr_q]));

  // Winner selection; the last assignment in each loop is the one that sticks.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    if (ARB_MODE == 0 || REQ_NUM == 1) begin
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        if (cand[i]) begin
          win_idx   = IDX_W'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      // Scan backwards from rr_ptr+REQ_NUM so rr_ptr+1 ends up with the final say.
      for (int unsigned k = REQ_NUM; k >= 1; k--) begin
        if (cand[(32'(rr_ptr_q) + k) % REQ_NUM]) begin
          win_idx   = IDX_W'((32'(rr_ptr_q) + k) % REQ_NUM);
          win_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rr_ptr_q     <= IDX_W'(REQ_NUM - 1);
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rr_ptr_q     <= rr_ptr_d;
      data_valid_q <= data_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rr_ptr_d     = rr_ptr_q;
    data_valid_d = data_valid_q;

    if (hready) begin
      data_d       = addr_q;
      data_valid_d = |grant_q;
    end

    unique case (state_q)
      StIdle: begin
        if (hready && win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          addr_d           = win_idx;
          rr_ptr_d         = win_idx;
          state_d          = StOwn;
        end
      end
      StOwn: begin
        if (rel) begin
          if (win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            addr_d           = win_idx;
            rr_ptr_d         = win_idx;
          end else begin
            grant_d = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant        = grant_q;
    grant_valid  = |grant_q;
    hmaster_addr = addr_q;
    hmaster_data = data_q;
    data_valid   = data_valid_q;
  end

endmodule

// File: tb/tb_ahb_arb_grant_ctrl.sv
// Bench for ahb_arb_grant_ctrl: a fixed-priority and a round-robin instance share stimulus,
// each checked against an owner-level reference model plus directed expectations.
module tb_ahb_arb_grant_ctrl;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [7:0] raw_grant, hlast;
  logic       hsel, hready;

  logic [7:0] g0, g1;
  logic       gv0, gv1, dv0, dv1;
  logic [2:0] a0, a1, d0, d1;

  int errors = 0;
  int checks = 0;

  // Reference model state per instance (0 = fixed, 1 = round-robin); owner -1 means none.
  int m_owner[2];
  int m_rr[2];
  int m_addr[2];
  int m_data[2];
  bit m_dv[2];

  always #5 hclk = ~hclk;

  ahb_arb_grant_ctrl #(.REQ_NUM(8), .ARB_MODE(0)) u_fix (
    .hclk(hclk), .hresetn(hresetn), .raw_grant(raw_grant), .hlast(hlast), .hsel(hsel),
    .hready(hready), .grant(g0), .grant_valid(gv0), .hmaster_addr(a0), .hmaster_data(d0),
    .data_valid(dv0)
  );

  ahb_arb_grant_ctrl #(.REQ_NUM(8), .ARB_MODE(1)) u_rr (
    .hclk(hclk), .hresetn(hresetn), .raw_grant(raw_grant), .hlast(hlast), .hsel(hsel),
    .hready(hready), .grant(g1), .grant_valid(gv1), .hmaster_addr(a1), .hmaster_data(d1),
    .data_valid(dv1)
  );

  function automatic int win(int mode, int rr, logic [7:0] v);
    if (v == 8'h00) return -1;
    if (mode == 0) begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= 8; k++) if (v[(rr + k) % 8]) return (rr + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_rr[m]    = 7;
      m_addr[m]  = 0;
      m_data[m]  = 0;
      m_dv[m]    = 1'b0;
    end
  endfunction

  function automatic void model_step();
    int nd, w, o;
    bit ndv, rel;
    logic [7:0] v;
    if (!hready) return;
    for (int m = 0; m < 2; m++) begin
      nd  = m_addr[m];
      ndv = (m_owner[m] >= 0);
      if (m_owner[m] < 0) begin
        w = win(m, m_rr[m], raw_grant);
        if (w >= 0) begin
          m_owner[m] = w; m_addr[m] = w; m_rr[m] = w;
        end
      end else begin
        o   = m_owner[m];
        rel = hsel ? hlast[o] : !raw_grant[o];
        if (rel) begin
          v    = raw_grant;
          v[o] = 1'b0;
          w    = win(m, m_rr[m], v);
          if (w >= 0) begin
            m_owner[m] = w; m_addr[m] = w; m_rr[m] = w;
          end else begin
            m_owner[m] = -1;
          end
        end
      end
      m_data[m] = nd;
      m_dv[m]   = ndv;
    end
  endfunction

  function automatic logic [15:0] exp_vec(int m);
    logic [7:0] g;
    g = 8'h00;
    if (m_owner[m] >= 0) g[m_owner[m]] = 1'b1;
    return {g, |g, 3'(m_addr[m]), 3'(m_data[m]), m_dv[m]};
  endfunction

  function automatic logic [15:0] dut_vec(int m);
    return (m == 0) ? {g0, gv0, a0, d0, dv0} : {g1, gv1, a1, d1, dv1};
  endfunction

  task automatic tick();
    @(posedge hclk);
    if (hresetn) model_step();
    #1;
  endtask

  task automatic apply_reset();
    hresetn = 1'b0; raw_grant = 8'h00; hlast = 8'h00; hsel = 1'b0; hready = 1'b1;
    model_reset();
    @(posedge hclk); #1;
    hresetn = 1'b1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; raw_grant = 8'hFF; hlast = 8'h00; hsel = 1'b0; hready = 1'b1;
    model_reset();
    repeat (2) tick();
    checks++;
    if ({dut_vec(0), dut_vec(1)} !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got %h/%h want 0000/0000", dut_vec(0), dut_vec(1));
    end
    hresetn = 1'b1;
    tick();
    checks++;
    if (g0 !== 8'h80 || a0 !== 3'd7) begin
      errors++;
      $display("FAIL reset_first_grant: got grant=%h addr=%0d want 80/7", g0, a0);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== exp_vec(m)) begin
        errors++;
        $display("FAIL reset_model[%0d]: got %h want %h", m, dut_vec(m), exp_vec(m));
      end
    end
    tick();
    checks++;
    if (d0 !== 3'd7 || dv0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_data_phase: got data=%0d dv=%b want 7/1", d0, dv0);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    apply_reset();
    raw_grant = 8'h05; hsel = 1'b1; hlast = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      tick();
      want = (i % 2 == 0) ? 8'h01 : 8'h04;
      checks++;
      if (g1 !== want) begin
        errors++;
        $display("FAIL rr_alternate beat %0d: got %h want %h", i, g1, want);
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL rr_model[%0d] beat %0d: got %h want %h", m, i, dut_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_burst_lock();
    apply_reset();
    raw_grant = 8'h08; hsel = 1'b1; hlast = 8'h00;
    tick();
    raw_grant = 8'h48;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (g0 !== 8'h08 || g1 !== 8'h08) begin
        errors++;
        $display("FAIL burst_lock beat %0d: got %h/%h want 08/08", i, g0, g1);
      end
    end
    hlast = 8'h08;
    tick();
    checks++;
    if (g0 !== 8'h40 || g1 !== 8'h40 || gv0 !== 1'b1 || gv1 !== 1'b1) begin
      errors++;
      $display("FAIL burst_handover: got %h/%h want 40/40", g0, g1);
    end
  endtask

  task automatic test_hready_stall();
    raw_grant = 8'h42; hlast = 8'h40; hsel = 1'b1; hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m) || a0 !== 3'd6) begin
          errors++;
          $display("FAIL stall_frozen[%0d] cyc %0d: got %h want %h", m, i, dut_vec(m), exp_vec(m));
        end
      end
    end
    hready = 1'b1;
    tick();
    checks++;
    if (g0 !== 8'h02 || a0 !== 3'd1 || g1 !== 8'h02 || a1 !== 3'd1) begin
      errors++;
      $display("FAIL stall_handover: got %h,%0d/%h,%0d want 02,1/02,1", g0, a0, g1, a1);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    raw_grant = 8'h04; hsel = 1'b0;
    tick();
    checks++;
    if (g0 !== 8'h04 || g1 !== 8'h04) begin
      errors++;
      $display("FAIL drop_grant: got %h/%h want 04/04", g0, g1);
    end
    raw_grant = 8'h00;
    tick();
    checks++;
    if (g0 !== 8'h00 || gv0 !== 1'b0 || dv0 !== 1'b1) begin
      errors++;
      $display("FAIL drop_release: got g=%h gv=%b dv=%b want 00/0/1", g0, gv0, dv0);
    end
    tick();
    checks++;
    if (dv0 !== 1'b0 || dv1 !== 1'b0) begin
      errors++;
      $display("FAIL drop_dv_fall: got %b/%b want 0/0", dv0, dv1);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    raw_grant = 8'h20; hsel = 1'b1; hlast = 8'h00;
    repeat (3) tick();
    checks++;
    if (g0 !== 8'h20 || dv0 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got g=%h dv=%b want 20/1", g0, dv0);
    end
    #2 hresetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({dut_vec(0), dut_vec(1)} !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async: got %h/%h want 0000/0000", dut_vec(0), dut_vec(1));
    end
    raw_grant = 8'h00;
    tick();
    hresetn = 1'b1;
    repeat (2) tick();
    checks++;
    if ({dut_vec(0), dut_vec(1)} !== 32'h0) begin
      errors++;
      $display("FAIL midrst_after: got %h/%h want 0000/0000", dut_vec(0), dut_vec(1));
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      raw_grant = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      hlast     = 8'($urandom);
      hsel      = 1'($urandom);
      hready    = ($urandom_range(0, 3) != 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL random[%0d] step %0d: got %h want %h", m, i, dut_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_hready_stall();
    test_drop();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_arb_grant_ctrl.md
Name: ahb_arb_grant_ctrl

Overview:
- Sequential back end of the per-slave AHB arbiter.
- Consumes the combinational raw_grant vector from the fixed-priority or burst-request detect stage and selects one winner, fixed or round-robin.
- Registers and holds the grant for the whole transfer or burst, releasing on the owner's last beat.
- Produces the address-phase master index and a one-cycle-delayed data-phase master index for the slave-side muxes.

Parameters:
- REQ_NUM, 8, number of requesting masters.
- ARB_MODE, 0, winner selection: 0 = fixed priority (highest index wins), 1 = round-robin.
- IDX_W, $clog2(REQ_NUM), width of master index outputs.

Ports:
- hclk  in  1  system clock, all state on rising edge.
- hresetn  in  1  asynchronous active-low reset.
- raw_grant  in  REQ_NUM  candidate vector from upstream mask stage; may be multi-hot.
- hlast  in  REQ_NUM  per-master last-beat-of-burst flag.
- hsel  in  1  this slave is selected by the current address phase.
- hready  in  1  slave ready; transfer phase advances only when 1.
- grant  out  REQ_NUM  registered one-hot grant, or all zero.
- grant_valid  out  1  equals |grant.
- hmaster_addr  out  IDX_W  index of the current owner (address phase).
- hmaster_data  out  IDX_W  owner index delayed one accepted beat (data phase).
- data_valid  out  1  data-phase owner valid.

Behaviour:
- Reset (hresetn=0, async):
  - grant=0, grant_valid=0, hmaster_addr=0, hmaster_data=0, data_valid=0.
  - state=IDLE, rr_ptr=REQ_NUM-1.
- Winner function win(v):
  - ARB_MODE=0: highest set index of v.
  - ARB_MODE=1: first set index scanning rr_ptr+1, rr_ptr+2, … modulo REQ_NUM.
  - v=0 yields no winner.
- State IDLE:
  - If hready=1 and |raw_grant, then on the next edge: grant=onehot(win(raw_grant)), hmaster_addr=win, rr_ptr=win, state=OWN.
  - Latency is raw_grant to grant = 1 cycle.
  - With hready=0, stay in IDLE.
- State OWN (owner o):
  - rel = hready & ((hsel & hlast[o]) | (~hsel & ~raw_grant[o])).
  - rel=0: grant and hmaster_addr hold unconditionally, regardless of other raw_grant bits. This is burst lock.
  - rel=1 and (raw_grant & ~onehot(o)) != 0: back-to-back handover. New grant = win(raw_grant & ~onehot(o)), rr_ptr updated, stay in OWN; no idle bubble.
  - rel=1 otherwise: grant=0, state=IDLE.
- Data-phase pipeline: on each edge with hready=1, hmaster_data<=hmaster_addr and data_valid<=grant_valid. With hready=0 both hold.
- hready=0: no output or state change except reset.
- Invariants:
  - grant is always one-hot or zero.
  - hmaster_addr is always consistent with grant when grant_valid=1.
  - rr_ptr changes only when a new grant is issued.
- Simultaneous last beat and new requests: the old owner is excluded for that handover even if its raw_grant bit remains set.
- Reset mid-burst: immediate return to the reset values above; no pending state survives.
- REQ_NUM=1: round-robin degenerates to fixed; the index is a 1-bit field tied to 0.

Test Plan:
- Reset with raw_grant=8'hFF, then release hresetn, hready=1, ARB_MODE=0: cycle 1 grant=8'h80, hmaster_addr=7; next beat hmaster_data=7, data_valid=1.
- ARB_MODE=1, raw_grant=8'h05 held, owner releases each beat via hsel=1 & hlast: grants alternate 8'h01, 8'h04, 8'h01, …; rr_ptr alternates 0/2.
- Burst lock: owner 3 granted, hsel=1, hlast[3]=0 for 4 beats while raw_grant[6]=1: grant stays 8'h08. hlast[3]=1 on beat 4: next cycle grant=8'h40 with no IDLE cycle.
- hready=0 for 3 cycles during handover with last beat pending: grant, hmaster_addr, hmaster_data frozen; handover occurs on the first hready=1 edge.
- Owner 2 drops request with hsel=0, raw_grant=0: next cycle grant=0, state IDLE; data_valid falls one accepted beat later.
- Assert hresetn=0 mid-burst (owner 5, 2 beats done): all outputs 0 asynchronously; after release with raw_grant=0 they remain 0.
